controle_jogo: RTL and testbench
================================

# controle_jogo

Blackjack round sequencer that sits between the deck ROM, the card-scoring unit and the player's buttons. It owns the deck read pointer, fetches each card, and routes it to the scoring unit on behalf of either the player or the dealer. It runs the fixed opening deal, then the player's hit/stay phase and the dealer's draw-to-limit phase. It then compares scores and publishes the round result.

## Interface
- DEALER_LIMIT, 17: dealer keeps drawing while pts_dealer < DEALER_LIMIT.
- MAX_PTS, 21: bust threshold; score > MAX_PTS is a bust.
- WDOG_CYCLES, 255: maximum cycles to wait for sc_ok before aborting.
- clock  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-high; clock clock.
- iniciar  in  1  single-cycle pulse, starts a round.
- hit  in  1  single-cycle pulse, player requests a card.
- stay  in  1  single-cycle pulse, player ends turn.
- deck_rd  out  1  deck ROM read strobe.
- deck_addr  out  6  deck ROM address (card pointer).
- deck_data  in  4  card value 1..13, valid the cycle after deck_rd.
- carta  out  4  card presented to the scoring unit.
- sc_pjogador  out  1  request: score carta for the player.
- sc_pdealer  out  1  request: score carta for the dealer.
- sc_ok  in  1  scoring unit done (level).
- pts_jogador  in  6  player score from the scoring unit.
- pts_dealer  in  6  dealer score from the scoring unit.
- resultado  out  2  00 none, 01 player wins, 10 dealer wins, 11 tie.
- fim_jogo  out  1  high while the result is valid.
- erro  out  1  sticky watchdog abort flag, cleared by iniciar or reset.
- n_cartas_jog  out  4  cards dealt to the player, saturates at 15.

## Operation
- States: OCIOSO, BUSCA, CAPTURA, PEDE, LIBERA, DECIDE, VEZ_JOG, VEZ_DEALER, RESULTADO.
- OCIOSO: on iniciar, clear resultado, fim_jogo, erro and n_cartas_jog, set deal index 0, go to BUSCA.
- Card fetch path: BUSCA → CAPTURA → PEDE → LIBERA → DECIDE.
  - BUSCA: deck_rd = 1 for one cycle, with deck_addr held.
  - CAPTURA: latch deck_data into carta, increment deck_addr (6-bit wrap 63→0). The destination (player or dealer) is latched in the same cycle.
  - PEDE: assert exactly one of sc_pjogador or sc_pdealer. Hold the request and carta stable until sc_ok = 1, then drop the request and go to LIBERA.
  - LIBERA: wait for sc_ok = 0, then go to DECIDE.
  - A player card increments n_cartas_jog (saturating).
- Opening deal order: player, dealer, player, dealer (deal index 0..3). DECIDE returns to BUSCA until index 3 has completed.
- After the opening deal, DECIDE goes to VEZ_JOG.
- VEZ_JOG:
  - pts_jogador > MAX_PTS → RESULTADO with 10.
  - pts_jogador == MAX_PTS → VEZ_DEALER (automatic stay).
  - stay → VEZ_DEALER.
  - hit (without stay) → BUSCA for a player card, which returns to VEZ_JOG.
  - If hit and stay arrive in the same cycle, stay wins.
- VEZ_DEALER:
  - pts_dealer < DEALER_LIMIT → BUSCA for a dealer card, which returns to VEZ_DEALER.
  - Otherwise → RESULTADO.
- RESULTADO, comparing scores:
  - Dealer bust → 01.
  - Player > dealer → 01.
  - Dealer > player → 10.
  - Equal → 11.
  - fim_jogo = 1 and resultado held until the next iniciar.
- Watchdog: counts cycles in PEDE and LIBERA. Reaching WDOG_CYCLES sets erro, drops both requests and returns to OCIOSO, with resultado = 00.
- Ignored inputs:
  - iniciar outside OCIOSO and RESULTADO is ignored. In RESULTADO it starts a new round without clearing deck_addr.
  - hit and stay outside VEZ_JOG are ignored.

## Timing
- Reset values: state OCIOSO, all outputs 0, deck_addr 0, carta 0.
- Reset mid-round: requests drop immediately (asynchronous) and the round is lost.
- Player hit latency: hit sampled in VEZ_JOG at cycle N.
  - deck_rd at N+1.
  - carta valid at N+3.
  - sc_pjogador high from N+3.
- Requests are never asserted together. A new request is issued only after sc_ok has been observed low.
- Scores are read only in VEZ_JOG, VEZ_DEALER and RESULTADO, which is at least one cycle after LIBERA.
- Score comparisons are 6-bit unsigned.

## Structure
- Shared package holds:
  - state encoding;
  - result codes (NENHUM, JOGADOR, DEALER, EMPATE);
  - DEALER_LIMIT and MAX_PTS defaults;
  - 6-bit score and 4-bit card widths.
- One sub-module, ponteiro_baralho: 6-bit wrapping deck pointer with increment enable, reset to 0.

## Test plan
- Deck 10,9,7,8 (player 17, dealer 17), then stay → four requests in order J,D,J,D; resultado 11; deck_addr 4.
- Deck 1,10,13,6, player stays with pts 21 → automatic VEZ_DEALER. Dealer draws 5 at 16 and stops at 21 → resultado 11. A variant with a dealer draw of 2 gives 18 → 01.
- Player 12 hits 13 (pts 22) → resultado 10 with no dealer draw. n_cartas_jog = 3.
- hit and stay pulsed in the same cycle → no deck_rd, VEZ_DEALER entered. A hit pulse during PEDE is ignored.
- sc_ok held low for 255 cycles → erro = 1, requests 0, state OCIOSO. The next iniciar clears erro.
- Reset asserted while sc_pdealer = 1 → all outputs 0 without waiting for the clock. deck_addr 0 after the next iniciar's first fetch.

Source files
------------

// File: rtl/controle_jogo_pkg.sv
// controle_jogo_pkg: types and constants shared by the blackjack round sequencer.
//   - estado_t    : sequencer state encoding
//   - resultado_t : round result codes driven on resultado
//   - score/card/address widths and default game limits
//   - compara()   : final score comparison at the end of the dealer turn
package controle_jogo_pkg;

  localparam int PTS_W   = 6;
  localparam int CARTA_W = 4;
  localparam int ADDR_W  = 6;

  localparam int DEALER_LIMIT_DEF = 17;
  localparam int MAX_PTS_DEF      = 21;
  localparam int WDOG_CYCLES_DEF  = 255;

  typedef enum logic [3:0] {
    OCIOSO, BUSCA, CAPTURA, PEDE, LIBERA, DECIDE, VEZ_JOG, VEZ_DEALER, RESULTADO
  } estado_t;

  typedef enum logic [1:0] {
    NENHUM  = 2'b00,
    JOGADOR = 2'b01,
    DEALER  = 2'b10,
    EMPATE  = 2'b11
  } resultado_t;

  // Player bust never gets here, so only the dealer can still be over the limit.
  function automatic resultado_t compara(input logic [PTS_W-1:0] pj,
                                         input logic [PTS_W-1:0] pd,
                                         input logic [PTS_W-1:0] max_pts);
    if (pd > max_pts)  return JOGADOR;
    else if (pj > pd)  return JOGADOR;
    else if (pd > pj)  return DEALER;
    else               return EMPATE;
  endfunction

endpackage

// File: rtl/controle_jogo_ponteiro_baralho.sv
// ponteiro_baralho: deck read pointer.
//   clock, reset : rising-edge clock, asynchronous active-high reset (pointer -> 0)
//   inc          : advance the pointer by one card (wraps 63 -> 0)
//   addr         : current deck ROM address
module ponteiro_baralho
  import controle_jogo_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              inc,
  output logic [ADDR_W-1:0] addr
);

  logic [ADDR_W-1:0] addr_q, addr_d;

  always_comb begin
    addr_d = addr_q;
    if (inc) addr_d = addr_q + ADDR_W'(1);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) addr_q <= '0;
    else       addr_q <= addr_d;
  end

  assign addr = addr_q;

endmodule

// File: rtl/controle_jogo.sv
// controle_jogo: blackjack round sequencer.
// Fetches cards from the deck ROM, hands each one to the scoring unit for the
// player or the dealer, runs opening deal / player turn / dealer turn and
// publishes the round result.
//   clock, reset        : rising-edge clock, asynchronous active-high reset
//   iniciar, hit, stay  : single-cycle button pulses
//   deck_rd, deck_addr  : deck ROM read strobe and card pointer
//   deck_data           : card value, valid the cycle after deck_rd
//   carta               : card presented to the scoring unit
//   sc_pjogador/pdealer : score request for player / dealer, held until sc_ok
//   sc_ok               : scoring unit done (level)
//   pts_jogador/dealer  : running scores from the scoring unit
//   resultado, fim_jogo : round result and its valid flag
//   erro                : sticky watchdog abort flag
//   n_cartas_jog        : cards dealt to the player (saturating)
module controle_jogo
  import controle_jogo_pkg::*;
#(
  parameter int DEALER_LIMIT = DEALER_LIMIT_DEF,
  parameter int MAX_PTS      = MAX_PTS_DEF,
  parameter int WDOG_CYCLES  = WDOG_CYCLES_DEF
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               iniciar,
  input  logic               hit,
  input  logic               stay,
  output logic               deck_rd,
  output logic [ADDR_W-1:0]  deck_addr,
  input  logic [CARTA_W-1:0] deck_data,
  output logic [CARTA_W-1:0] carta,
  output logic               sc_pjogador,
  output logic               sc_pdealer,
  input  logic               sc_ok,
  input  logic [PTS_W-1:0]   pts_jogador,
  input  logic [PTS_W-1:0]   pts_dealer,
  output logic [1:0]         resultado,
  output logic               fim_jogo,
  output logic               erro,
  output logic [3:0]         n_cartas_jog
);

  localparam int                WD_W      = $clog2(WDOG_CYCLES + 1);
  localparam logic [WD_W-1:0]   WD_ULTIMO = WD_W'(WDOG_CYCLES - 1);
  localparam logic [PTS_W-1:0]  LIM_P     = PTS_W'(DEALER_LIMIT);
  localparam logic [PTS_W-1:0]  MAX_P     = PTS_W'(MAX_PTS);

  estado_t            estado_q, estado_d;
  logic               deck_rd_q, deck_rd_d;
  logic [CARTA_W-1:0] carta_q, carta_d;
  logic               req_jog_q, req_jog_d;
  logic               req_dlr_q, req_dlr_d;
  resultado_t         resultado_q, resultado_d;
  logic               fim_q, fim_d;
  logic               erro_q, erro_d;
  logic [3:0]         ncj_q, ncj_d;
  logic [1:0]         idx_q, idx_d;        // opening deal index 0..3
  logic               abertura_q, abertura_d; // still in the opening deal
  logic               vez_jog_q, vez_jog_d;   // extra card belongs to the player
  logic [WD_W-1:0]    wdog_q, wdog_d;
  logic               avanca;
  logic               para_jog;

  ponteiro_baralho u_ponteiro (
    .clock (clock),
    .reset (reset),
    .inc   (avanca),
    .addr  (deck_addr)
  );

  always_comb begin
    estado_d    = estado_q;
    deck_rd_d   = 1'b0;
    carta_d     = carta_q;
    req_jog_d   = 1'b0;
    req_dlr_d   = 1'b0;
    resultado_d = resultado_q;
    fim_d       = fim_q;
    erro_d      = erro_q;
    ncj_d       = ncj_q;
    idx_d       = idx_q;
    abertura_d  = abertura_q;
    vez_jog_d   = vez_jog_q;
    wdog_d      = '0;
    avanca      = 1'b0;
    // Opening deal alternates player/dealer on the index LSB.
    para_jog    = abertura_q ? ~idx_q[0] : vez_jog_q;

    unique case (estado_q)
      OCIOSO, RESULTADO: begin
        if (iniciar) begin
          resultado_d = NENHUM;
          fim_d       = 1'b0;
          erro_d      = 1'b0;
          ncj_d       = '0;
          idx_d       = '0;
          abertura_d  = 1'b1;
          deck_rd_d   = 1'b1;
          estado_d    = BUSCA;
        end
      end
      BUSCA: estado_d = CAPTURA;
      CAPTURA: begin
        carta_d   = deck_data;
        avanca    = 1'b1;
        req_jog_d = para_jog;
        req_dlr_d = ~para_jog;
        if (para_jog && ncj_q != 4'hf) ncj_d = ncj_q + 4'd1;
        estado_d  = PEDE;
      end
      PEDE: begin
        wdog_d = wdog_q + WD_W'(1);
        if (sc_ok) estado_d = LIBERA;
        else begin
          req_jog_d = req_jog_q;
          req_dlr_d = req_dlr_q;
        end
      end
      LIBERA: begin
        wdog_d = wdog_q + WD_W'(1);
        if (!sc_ok) estado_d = DECIDE;
      end
      DECIDE: begin
        if (abertura_q) begin
          if (idx_q == 2'd3) begin
            abertura_d = 1'b0;
            estado_d   = VEZ_JOG;
          end else begin
            idx_d     = idx_q + 2'd1;
            deck_rd_d = 1'b1;
            estado_d  = BUSCA;
          end
        end else begin
          estado_d = vez_jog_q ? VEZ_JOG : VEZ_DEALER;
        end
      end
      VEZ_JOG: begin
        if (pts_jogador > MAX_P) begin
          resultado_d = DEALER;
          fim_d       = 1'b1;
          estado_d    = RESULTADO;
        end else if (pts_jogador == MAX_P || stay) begin
          estado_d = VEZ_DEALER;
        end else if (hit) begin
          vez_jog_d = 1'b1;
          deck_rd_d = 1'b1;
          estado_d  = BUSCA;
        end
      end
      VEZ_DEALER: begin
        if (pts_dealer < LIM_P) begin
          vez_jog_d = 1'b0;
          deck_rd_d = 1'b1;
          estado_d  = BUSCA;
        end else begin
          resultado_d = compara(pts_jogador, pts_dealer, MAX_P);
          fim_d       = 1'b1;
          estado_d    = RESULTADO;
        end
      end
      default: estado_d = OCIOSO;
    endcase

    // Scoring unit stuck: abandon the round, regardless of sc_ok this cycle.
    if ((estado_q == PEDE || estado_q == LIBERA) && wdog_q == WD_ULTIMO) begin
      erro_d      = 1'b1;
      req_jog_d   = 1'b0;
      req_dlr_d   = 1'b0;
      resultado_d = NENHUM;
      fim_d       = 1'b0;
      wdog_d      = '0;
      estado_d    = OCIOSO;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q    <= OCIOSO;
      deck_rd_q   <= 1'b0;
      carta_q     <= '0;
      req_jog_q   <= 1'b0;
      req_dlr_q   <= 1'b0;
      resultado_q <= NENHUM;
      fim_q       <= 1'b0;
      erro_q      <= 1'b0;
      ncj_q       <= '0;
      idx_q       <= '0;
      abertura_q  <= 1'b0;
      vez_jog_q   <= 1'b0;
      wdog_q      <= '0;
    end else begin
      estado_q    <= estado_d;
      deck_rd_q   <= deck_rd_d;
      carta_q     <= carta_d;
      req_jog_q   <= req_jog_d;
      req_dlr_q   <= req_dlr_d;
      resultado_q <= resultado_d;
      fim_q       <= fim_d;
      erro_q      <= erro_d;
      ncj_q       <= ncj_d;
      idx_q       <= idx_d;
      abertura_q  <= abertura_d;
      vez_jog_q   <= vez_jog_d;
      wdog_q      <= wdog_d;
    end
  end

  assign deck_rd      = deck_rd_q;
  assign carta        = carta_q;
  assign sc_pjogador  = req_jog_q;
  assign sc_pdealer   = req_dlr_q;
  assign resultado    = resultado_q;
  assign fim_jogo     = fim_q;
  assign erro         = erro_q;
  assign n_cartas_jog = ncj_q;

endmodule

// File: tb/tb_controle_jogo.sv
// tb_controle_jogo: directed bench for controle_jogo with a deck ROM and a
// simple scoring-unit model (ace 11, faces 10) driven from the bench.
module tb_controle_jogo;

  logic       clock = 1'b0;
  logic       reset, iniciar, hit, stay;
  logic       deck_rd;
  logic [5:0] deck_addr;
  logic [3:0] deck_data, carta;
  logic       sc_pjogador, sc_pdealer, sc_ok;
  logic [5:0] pts_jogador, pts_dealer;
  logic [1:0] resultado;
  logic       fim_jogo, erro;
  logic [3:0] n_cartas_jog;

  controle_jogo dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .hit(hit), .stay(stay),
    .deck_rd(deck_rd), .deck_addr(deck_addr), .deck_data(deck_data), .carta(carta),
    .sc_pjogador(sc_pjogador), .sc_pdealer(sc_pdealer), .sc_ok(sc_ok),
    .pts_jogador(pts_jogador), .pts_dealer(pts_dealer), .resultado(resultado),
    .fim_jogo(fim_jogo), .erro(erro), .n_cartas_jog(n_cartas_jog)
  );

  initial forever #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  // ---------------- deck ROM + scoring unit model ----------------
  logic [3:0]  rom [64];
  logic        rd_pend = 1'b0;
  logic [5:0]  rd_addr = '0;
  int          rd_cnt = 0;
  int          log_n = 0;
  logic [31:0] log_dest = '0;  // bit i set when request i went to the dealer
  int          sc_limit = 1000; // model serves requests only while log_n < sc_limit
  logic [5:0]  exp_addr = '0;

  function automatic logic [5:0] valor(input logic [3:0] c);
    if (c == 4'd1)      return 6'd11;
    else if (c > 4'd10) return 6'd10;
    else                return {2'b00, c};
  endfunction

  initial begin
    forever begin
      @(negedge clock);
      if (rd_pend) begin
        deck_data = rom[rd_addr];
        rd_pend   = 1'b0;
      end
      if (deck_rd) begin
        rd_pend = 1'b1;
        rd_addr = deck_addr;
        rd_cnt++;
      end
      if ((sc_pjogador || sc_pdealer) && !sc_ok && log_n < sc_limit) begin
        chk("req_onehot", {31'd0, sc_pjogador & sc_pdealer}, 32'd0);
        if (sc_pjogador) pts_jogador = pts_jogador + valor(carta);
        else begin
          pts_dealer      = pts_dealer + valor(carta);
          log_dest[log_n] = 1'b1;
        end
        log_n++;
        sc_ok = 1'b1;
      end else if (!sc_pjogador && !sc_pdealer && sc_ok) begin
        sc_ok = 1'b0;
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic start_round(input logic [7:0][3:0] d, input int n);
    for (int i = 0; i < n; i++) rom[exp_addr + 6'(i)] = d[i];
    pts_jogador = '0;
    pts_dealer  = '0;
    log_n       = 0;
    log_dest    = '0;
    iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
  endtask

  task automatic wait_idle(input int n);
    for (int k = 0; k < 100 && !(log_n == n && !sc_ok); k++) tick();
    chk("wait_idle_timeout", log_n, n);
  endtask

  task automatic wait_fim;
    for (int k = 0; k < 200 && !fim_jogo; k++) tick();
    chk("wait_fim_timeout", {31'd0, fim_jogo}, 32'd1);
  endtask

  task automatic pulse_hit;
    hit = 1'b1; tick(); hit = 1'b0;
  endtask

  task automatic pulse_stay;
    stay = 1'b1; tick(); stay = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [7:0][3:0] deck;  // card i in nibble i
    int              ncards;
    int              hits;
    logic [1:0]      res;
    int              ncj;
    logic [7:0]      dest;
  } vec_t;

  vec_t vt [7];

  initial begin
    int rd0;
    reset = 1'b1; iniciar = 1'b0; hit = 1'b0; stay = 1'b0;
    sc_ok = 1'b0; deck_data = '0; pts_jogador = '0; pts_dealer = '0;
    for (int i = 0; i < 64; i++) rom[i] = 4'd0;

    // J 10+7=17, D 9+8=17 -> tie
    vt[0] = '{32'h0000_879A, 4, 0, 2'b11, 2, 8'b0000_1010};
    // J 11+10=21 auto stay, D 16 draws 5 -> 21 tie
    vt[1] = '{32'h0005_6DA1, 5, 0, 2'b11, 2, 8'b0001_1010};
    // same, dealer draws 2 -> 18, player 21 wins
    vt[2] = '{32'h0002_6DA1, 5, 0, 2'b01, 2, 8'b0001_1010};
    // J 12 hits 13 -> 22 bust, dealer never draws
    vt[3] = '{32'h000D_725A, 5, 1, 2'b10, 3, 8'b0000_1010};
    // J 18, D 16 draws 9 -> 25 bust, player wins
    vt[4] = '{32'h0009_68AA, 5, 0, 2'b01, 2, 8'b0001_1010};
    // J 17, D 19 -> dealer wins
    vt[5] = '{32'h0000_97AA, 4, 0, 2'b10, 2, 8'b0000_1010};
    // J 5 hits 4 and 5 -> 14, D 17 -> dealer wins
    vt[6] = '{32'h0054_73A2, 6, 2, 2'b10, 4, 8'b0000_1010};

    // reset state
    #2;
    chk("rst_deck_rd", {31'd0, deck_rd}, 0);
    chk("rst_deck_addr", {26'd0, deck_addr}, 0);
    chk("rst_carta", {28'd0, carta}, 0);
    chk("rst_reqs", {30'd0, sc_pjogador, sc_pdealer}, 0);
    chk("rst_res", {30'd0, resultado}, 0);
    chk("rst_flags", {30'd0, fim_jogo, erro}, 0);
    chk("rst_ncj", {28'd0, n_cartas_jog}, 0);
    tick(); reset = 1'b0; tick();

    // ---- table-driven rounds ----
    foreach (vt[v]) begin
      start_round(vt[v].deck, vt[v].ncards);
      chk($sformatf("v%0d_fim_clear", v), {31'd0, fim_jogo}, 0);
      chk($sformatf("v%0d_res_clear", v), {30'd0, resultado}, 0);
      wait_idle(4);
      repeat (2) tick();
      for (int h = 0; h < vt[v].hits; h++) begin
        pulse_hit();
        wait_idle(5 + h);
        repeat (2) tick();
      end
      pulse_stay();
      wait_fim();
      chk($sformatf("v%0d_resultado", v), {30'd0, resultado}, {30'd0, vt[v].res});
      chk($sformatf("v%0d_ncj", v), {28'd0, n_cartas_jog}, vt[v].ncj);
      chk($sformatf("v%0d_nreq", v), log_n, vt[v].ncards);
      chk($sformatf("v%0d_dest", v), log_dest, {24'd0, vt[v].dest});
      chk($sformatf("v%0d_deck_addr", v), {26'd0, deck_addr}, {26'd0, exp_addr + 6'(vt[v].ncards)});
      chk($sformatf("v%0d_erro", v), {31'd0, erro}, 0);
      exp_addr = exp_addr + 6'(vt[v].ncards);
      repeat (3) tick();
    end
    chk("res_held", {30'd0, resultado}, 2'b10);
    chk("fim_held", {31'd0, fim_jogo}, 1);

    // ---- hit latency, hit ignored during PEDE ----
    start_round(32'h0002_879A, 5);
    wait_idle(4);
    repeat (2) tick();
    sc_limit = 4;
    hit = 1'b1; tick(); hit = 1'b0;             // sampled at cycle N
    chk("lat_rd_n1", {31'd0, deck_rd}, 1);
    tick();
    chk("lat_rd_n2", {31'd0, deck_rd}, 0);
    chk("lat_req_n2", {31'd0, sc_pjogador}, 0);
    tick();
    chk("lat_req_n3", {30'd0, sc_pjogador, sc_pdealer}, 2'b10);
    chk("lat_carta_n3", {28'd0, carta}, 2);
    rd0 = rd_cnt;
    pulse_hit();
    repeat (3) tick();
    chk("pede_hold_req", {31'd0, sc_pjogador}, 1);
    chk("pede_hold_carta", {28'd0, carta}, 2);
    chk("pede_hit_ignored", rd_cnt, rd0);
    sc_limit = 1000;
    wait_idle(5);
    repeat (2) tick();
    pulse_stay();
    wait_fim();
    chk("lat_resultado", {30'd0, resultado}, 2'b01);
    chk("lat_ncj", {28'd0, n_cartas_jog}, 3);
    chk("lat_nrd", rd_cnt, rd0);
    exp_addr = exp_addr + 6'd5;

    // ---- hit and stay in the same cycle: stay wins ----
    start_round(32'h0000_879A, 4);
    wait_idle(4);
    repeat (2) tick();
    rd0 = rd_cnt;
    hit = 1'b1; stay = 1'b1; tick(); hit = 1'b0; stay = 1'b0;
    wait_fim();
    chk("hs_no_deck_rd", rd_cnt, rd0);
    chk("hs_resultado", {30'd0, resultado}, 2'b11);
    chk("hs_nreq", log_n, 4);
    exp_addr = exp_addr + 6'd4;

    // ---- watchdog ----
    sc_limit = 0;
    start_round(32'h0000_000A, 1);
    for (int k = 0; k < 20 && !sc_pjogador; k++) tick();
    chk("wd_req_seen", {31'd0, sc_pjogador}, 1);  // first PEDE cycle
    repeat (254) tick();                          // 255th PEDE cycle
    chk("wd_req_254", {31'd0, sc_pjogador}, 1);
    chk("wd_erro_254", {31'd0, erro}, 0);
    tick();
    chk("wd_erro", {31'd0, erro}, 1);
    chk("wd_reqs_drop", {30'd0, sc_pjogador, sc_pdealer}, 0);
    chk("wd_res", {30'd0, resultado}, 0);
    chk("wd_fim", {31'd0, fim_jogo}, 0);
    exp_addr = exp_addr + 6'd1;
    rd0 = rd_cnt;
    pulse_hit();
    repeat (3) tick();
    chk("wd_idle_hit_ignored", rd_cnt, rd0);
    chk("wd_erro_sticky", {31'd0, erro}, 1);
    sc_limit = 1000;
    start_round(32'h0000_879A, 4);
    chk("wd_erro_cleared", {31'd0, erro}, 0);
    chk("wd_restart_rd", {31'd0, deck_rd}, 1);
    wait_idle(4);
    repeat (2) tick();
    pulse_stay();
    wait_fim();
    chk("wd_round_res", {30'd0, resultado}, 2'b11);
    exp_addr = exp_addr + 6'd4;
    chk("wd_round_addr", {26'd0, deck_addr}, {26'd0, exp_addr});

    // ---- asynchronous reset mid-round ----
    sc_limit = 1;
    start_round(32'h0000_879A, 4);
    for (int k = 0; k < 40 && !sc_pdealer; k++) tick();
    chk("ar_dealer_req", {31'd0, sc_pdealer}, 1);
    #2 reset = 1'b1;
    #1;
    chk("ar_reqs", {30'd0, sc_pjogador, sc_pdealer}, 0);
    chk("ar_addr", {26'd0, deck_addr}, 0);
    chk("ar_carta", {28'd0, carta}, 0);
    chk("ar_outs", {27'd0, deck_rd, resultado, fim_jogo, erro}, 0);
    chk("ar_ncj", {28'd0, n_cartas_jog}, 0);
    tick(); reset = 1'b0; tick();
    exp_addr = '0;
    sc_limit = 1000;
    start_round(32'h0000_879A, 4);
    chk("ar_first_rd", {31'd0, deck_rd}, 1);
    chk("ar_first_addr", {26'd0, deck_addr}, 0);
    wait_idle(4);
    repeat (2) tick();
    pulse_stay();
    wait_fim();
    chk("ar_round_res", {30'd0, resultado}, 2'b11);
    chk("ar_round_addr", {26'd0, deck_addr}, 4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
